dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory (dmem) between the pipelined CPU MEM stage and a
//  debug/loader port (testbench preload, register dump, future DMA). The CPU has priority;
//  the debug port is guaranteed service within 1 cycle. Debug tenure is limited to
//  DBG_BURST transfers, which bounds CPU stall. Sits between the MEM stage/hazard unit and dmem.
// PARAMETERS
//  DATA_W     32  data width of both ports and of dmem
//  ADDR_W     32  byte address width; passed to dmem unchanged
//  DBG_BURST  4   max consecutive debug transfers per tenure (>=1)
// PORTS
//  clk         in   1       clock; all state updates on posedge
//  reset       in   1       synchronous, active-high
//  cpu_req     in   1       MEM stage load/store request
//  cpu_we      in   1       1 = store
//  cpu_a       in   ADDR_W  byte address
//  cpu_wd      in   DATA_W  store data
//  cpu_gnt     out  1       access performed this cycle
//  cpu_rd      out  DATA_W  load data; valid in the cycle cpu_gnt=1 (combinational from mem_rd)
//  cpu_stall   out  1       cpu_req & ~cpu_gnt; feeds hazard unit to freeze IF/ID/EX/MEM
//  dbg_req     in   1       debug request; held with dbg_we/a/wd stable until dbg_gnt
//  dbg_we      in   1       1 = write
//  dbg_a       in   ADDR_W  byte address
//  dbg_wd      in   DATA_W  write data
//  dbg_gnt     out  1       access performed this cycle
//  dbg_rvalid  out  1       1-cycle pulse, the cycle after a granted debug read
//  dbg_rdata   out  DATA_W  registered read data; holds its value until the next debug read
//  mem_we      out  1       to dmem we
//  mem_a       out  ADDR_W  to dmem a
//  mem_wd      out  DATA_W  to dmem wd
//  mem_rd      in   DATA_W  from dmem rd (asynchronous read)
//  stat_cpu_stall  out 32   CPU stall-cycle count (see CONFIGURATION)
//  stat_dbg_xfer   out 32   debug transfer count (see CONFIGURATION)
// BEHAVIOUR
//  - State: mode {CPU_PRI, DBG_TURN}, burst_cnt [$clog2(DBG_BURST):0].
//  - Grants (combinational):
//    CPU_PRI:  cpu_gnt = cpu_req;              dbg_gnt = dbg_req & ~cpu_req.
//    DBG_TURN: dbg_gnt = dbg_req;              cpu_gnt = cpu_req & ~dbg_req.
//    cpu_gnt and dbg_gnt are never both 1.
//  - Mem mux: the granted port drives mem_a/mem_wd; mem_we = granted port's we.
//    With no grant: mem_a = cpu_a, mem_wd = cpu_wd, mem_we = 0.
//  - Transitions at posedge:
//    CPU_PRI -> DBG_TURN when cpu_req & dbg_req (debug denied this cycle); burst_cnt <= 0.
//    DBG_TURN: on dbg_gnt, burst_cnt++. Return to CPU_PRI (burst_cnt <= 0) when ~dbg_req,
//    or when dbg_gnt & burst_cnt == DBG_BURST-1. Otherwise stay in DBG_TURN.
//  - Bounds: debug waits <= 1 cycle; CPU stalls <= DBG_BURST consecutive cycles.
//    DBG_BURST=1 gives strict alternation under contention.
//  - Debug read: on dbg_gnt & ~dbg_we, dbg_rdata <= mem_rd and dbg_rvalid <= 1 at that edge;
//    otherwise dbg_rvalid <= 0.
//  - Writes commit at the dmem posedge of the grant cycle. A read in the cycle after a write
//    to the same address returns the new data.
//  - Reset (takes priority, and also applies mid-tenure): mode=CPU_PRI, burst_cnt=0,
//    dbg_rvalid=0, dbg_rdata=0, stat counters=0.
//    While reset=1: cpu_gnt=dbg_gnt=mem_we=0 and cpu_stall=cpu_req. Nothing is written to dmem.
//  - Idle (no req): mode holds CPU_PRI, or DBG_TURN exits to CPU_PRI on the next edge.
// CONFIGURATION
//  DMEM_ARB_STATS_EN defined:
//    - stat_cpu_stall increments on every cycle with cpu_stall=1.
//    - stat_dbg_xfer increments on every dbg_gnt.
//    - Both are 32-bit, saturate at 32'hFFFFFFFF, and are cleared by reset.
//  Undefined: both stat ports tied to 0 and the counter flops are not built.
// TESTING
//  1 CPU only: cpu_req every cycle, alternating sw/lw at a=0x10, wd=0xDEADBEEF
//    -> cpu_gnt always 1, cpu_stall 0, the lw returns 0xDEADBEEF.
//  2 Debug only: writes to 0x0,0x4,0x8 then read 0x4 -> dbg_gnt each cycle;
//    dbg_rvalid pulses 1 cycle after the read with dbg_rdata equal to the 0x4 data.
//  3 Contention, DBG_BURST=4: cpu_req and dbg_req held high
//    -> pattern CPU,DBG,DBG,DBG,DBG,CPU,DBG...; cpu_stall high for exactly 4 cycles.
//  4 Reset asserted mid debug tenure (burst_cnt=2)
//    -> next cycle mode=CPU_PRI, grants 0 during reset, dmem unchanged.
//  5 Single debug request while CPU busy
//    -> dbg_gnt within 1 cycle, then the arbiter returns to CPU_PRI.
//  6 DMEM_ARB_STATS_EN defined, scenario 3 run for 10 cycles
//    -> stat_cpu_stall=8, stat_dbg_xfer=8.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port data memory between the CPU MEM stage and a
//   debug/loader port. The CPU normally wins; a denied debug request is
//   guaranteed a grant on the following cycle. A debug tenure is capped at
//   DBG_BURST transfers, which bounds how long the CPU can be stalled.
//
//   Optional feature macro: DMEM_ARB_STATS_EN
//     defined   -> saturating 32-bit stall / debug-transfer counters are built
//     undefined -> stat_cpu_stall and stat_dbg_xfer are tied to zero
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   cpu_req/we/a/wd, cpu_gnt       CPU request and grant
//   cpu_rd                         load data (combinational from mem_rd)
//   cpu_stall                      cpu_req & ~cpu_gnt, to the hazard unit
//   dbg_req/we/a/wd, dbg_gnt       debug request and grant
//   dbg_rvalid, dbg_rdata          registered debug read return
//   mem_we/a/wd, mem_rd            dmem interface (asynchronous read)
//   stat_cpu_stall, stat_dbg_xfer  statistics counters
//
// state    | meaning
// CPU_PRI  | CPU has priority; a colliding debug request is denied once
// DBG_TURN | debug has priority for up to DBG_BURST granted transfers

module dmem_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int DBG_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_a,
    input  logic [DATA_W-1:0] cpu_wd,
    output logic              cpu_gnt,
    output logic [DATA_W-1:0] cpu_rd,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_a,
    input  logic [DATA_W-1:0] dbg_wd,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic [31:0]       stat_cpu_stall,
    output logic [31:0]       stat_dbg_xfer
);

    localparam int CNT_W = $clog2(DBG_BURST) + 1;
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(DBG_BURST - 1);

    typedef enum logic {
        CPU_PRI  = 1'b0,
        DBG_TURN = 1'b1
    } mode_t;

    mode_t            mode, mode_nxt;
    logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            mode      <= CPU_PRI;
            burst_cnt <= '0;
        end else begin
            mode      <= mode_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    // Grants are forced low during reset so nothing reaches dmem.
    always_comb begin
        cpu_gnt       = 1'b0;
        dbg_gnt       = 1'b0;
        mode_nxt      = mode;
        burst_cnt_nxt = burst_cnt;
        case (mode)
            CPU_PRI: begin
                cpu_gnt = cpu_req & ~reset;
                dbg_gnt = dbg_req & ~cpu_req & ~reset;
                if (cpu_req && dbg_req) begin
                    mode_nxt      = DBG_TURN;
                    burst_cnt_nxt = '0;
                end
            end
            DBG_TURN: begin
                dbg_gnt = dbg_req & ~reset;
                cpu_gnt = cpu_req & ~dbg_req & ~reset;
                // In this mode a pending debug request is always the one granted.
                if (!dbg_req || burst_cnt == BURST_LAST) begin
                    mode_nxt      = CPU_PRI;
                    burst_cnt_nxt = '0;
                end else begin
                    burst_cnt_nxt = burst_cnt + CNT_W'(1);
                end
            end
            default: begin
                mode_nxt      = CPU_PRI;
                burst_cnt_nxt = '0;
            end
        endcase
    end

    // With no grant the CPU address/data sit on the bus but mem_we stays low.
    assign mem_a     = dbg_gnt ? dbg_a  : cpu_a;
    assign mem_wd    = dbg_gnt ? dbg_wd : cpu_wd;
    assign mem_we    = (cpu_gnt & cpu_we) | (dbg_gnt & dbg_we);
    assign cpu_rd    = mem_rd;
    assign cpu_stall = cpu_req & ~cpu_gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= '0;
        end else begin
            dbg_rvalid <= dbg_gnt & ~dbg_we;
            if (dbg_gnt && !dbg_we) begin
                dbg_rdata <= mem_rd;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stall_q;
    logic [31:0] xfer_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            xfer_q  <= '0;
        end else begin
            if (cpu_stall && stall_q != 32'hFFFF_FFFF) begin
                stall_q <= stall_q + 32'd1;
            end
            if (dbg_gnt && xfer_q != 32'hFFFF_FFFF) begin
                xfer_q <= xfer_q + 32'd1;
            end
        end
    end

    assign stat_cpu_stall = stall_q;
    assign stat_dbg_xfer  = xfer_q;
`else
    assign stat_cpu_stall = 32'd0;
    assign stat_dbg_xfer  = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Self-checking bench for dmem_arbiter (default parameters, DBG_BURST=4).
//   A behavioural dmem with asynchronous read sits on the mem_* bus; a
//   separate shadow array tracks what memory should hold. Expected read data
//   is queued when a read is driven and popped when the DUT returns it.

module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_stall;
    logic [31:0] cpu_a, cpu_wd, cpu_rd;
    logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_a, dbg_wd, dbg_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic [31:0] stat_cpu_stall, stat_dbg_xfer;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] dmem   [0:63] = '{default: '0};
    logic [31:0] shadow [0:63] = '{default: '0};
    logic [31:0] sb_q   [$];
    logic [31:0] exp_v;

`ifdef DMEM_ARB_STATS_EN
    localparam logic [31:0] EXP_STAT = 32'd8;
`else
    localparam logic [31:0] EXP_STAT = 32'd0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) dmem[mem_a[7:2]] <= mem_wd;
    end
    assign mem_rd = dmem[mem_a[7:2]];

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_wd(cpu_wd),
        .cpu_gnt(cpu_gnt), .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_a(dbg_a), .dbg_wd(dbg_wd),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .stat_cpu_stall(stat_cpu_stall), .stat_dbg_xfer(stat_dbg_xfer)
    );

    task automatic set_cpu(input logic req, input logic we, input logic [31:0] a, input logic [31:0] wd);
        cpu_req = req; cpu_we = we; cpu_a = a; cpu_wd = wd;
    endtask

    task automatic set_dbg(input logic req, input logic we, input logic [31:0] a, input logic [31:0] wd);
        dbg_req = req; dbg_we = we; dbg_a = a; dbg_wd = wd;
    endtask

    task automatic set_idle();
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic pulse_reset();
        set_idle();
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Reset held with colliding write requests: no grant, no write, outputs cleared.
    task automatic test_reset();
        reset = 1'b1;
        set_cpu(1'b1, 1'b1, 32'h40, 32'h1234_5678);
        set_dbg(1'b1, 1'b1, 32'h44, 32'h55AA_55AA);
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++; if (cpu_gnt !== 1'b0) begin miscompares++; $display("FAIL reset_cpu_gnt: got %b want 0", cpu_gnt); end
            vectors++; if (dbg_gnt !== 1'b0) begin miscompares++; $display("FAIL reset_dbg_gnt: got %b want 0", dbg_gnt); end
            vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
            vectors++; if (cpu_stall !== 1'b1) begin miscompares++; $display("FAIL reset_cpu_stall: got %b want 1", cpu_stall); end
            @(posedge clk); #1;
            vectors++; if (dbg_rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid: got %b want 0", dbg_rvalid); end
            vectors++; if (dbg_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", dbg_rdata); end
            vectors++; if (stat_cpu_stall !== 32'h0) begin miscompares++; $display("FAIL reset_stat_stall: got %0d want 0", stat_cpu_stall); end
            vectors++; if (stat_dbg_xfer !== 32'h0) begin miscompares++; $display("FAIL reset_stat_xfer: got %0d want 0", stat_dbg_xfer); end
            @(negedge clk);
        end
        set_idle();
        reset = 1'b0;
        #1;
        vectors++; if (dmem[16] !== shadow[16]) begin miscompares++; $display("FAIL reset_dmem_cpu: got %h want %h", dmem[16], shadow[16]); end
        vectors++; if (dmem[17] !== shadow[17]) begin miscompares++; $display("FAIL reset_dmem_dbg: got %h want %h", dmem[17], shadow[17]); end
        @(negedge clk);
    endtask

    // Alternating store/load at 0x10; each load returns the preceding store.
    task automatic test_cpu_only();
        logic        we;
        logic [31:0] wd;
        for (int i = 0; i < 8; i++) begin
            we = (i % 2 == 0);
            wd = (i < 2) ? 32'hDEAD_BEEF : (32'hDEAD_BEEF ^ 32'(i * 32'h0101_0101));
            set_cpu(1'b1, we, 32'h10, wd);
            set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
            if (!we) sb_q.push_back(shadow[4]);
            #1;
            vectors++; if (cpu_gnt !== 1'b1) begin miscompares++; $display("FAIL cpu_gnt[%0d]: got %b want 1", i, cpu_gnt); end
            vectors++; if (cpu_stall !== 1'b0) begin miscompares++; $display("FAIL cpu_stall[%0d]: got %b want 0", i, cpu_stall); end
            vectors++; if (dbg_gnt !== 1'b0) begin miscompares++; $display("FAIL cpu_dbg_gnt[%0d]: got %b want 0", i, dbg_gnt); end
            vectors++; if (mem_we !== we) begin miscompares++; $display("FAIL cpu_mem_we[%0d]: got %b want %b", i, mem_we, we); end
            vectors++; if (mem_a !== 32'h10) begin miscompares++; $display("FAIL cpu_mem_a[%0d]: got %h want 10", i, mem_a); end
            if (we) begin
                vectors++; if (mem_wd !== wd) begin miscompares++; $display("FAIL cpu_mem_wd[%0d]: got %h want %h", i, mem_wd, wd); end
            end else begin
                exp_v = sb_q.pop_front();
                vectors++; if (cpu_rd !== exp_v) begin miscompares++; $display("FAIL cpu_lw[%0d]: got %h want %h", i, cpu_rd, exp_v); end
            end
            @(posedge clk);
            if (we) shadow[4] = wd;
            #1;
            @(negedge clk);
        end
        set_idle();
    endtask

    // Debug writes to 0x0/0x4/0x8 then reads 0x4; rvalid pulses once and rdata holds.
    task automatic test_debug_only();
        logic [31:0] da [4];
        logic [31:0] dd [4];
        logic        dw [4];
        logic [31:0] held;
        da = '{32'h0, 32'h4, 32'h8, 32'h4};
        dd = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h0};
        dw = '{1'b1, 1'b1, 1'b1, 1'b0};
        held = 32'h0;
        for (int i = 0; i < 4; i++) begin
            set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
            set_dbg(1'b1, dw[i], da[i], dd[i]);
            if (!dw[i]) sb_q.push_back(shadow[da[i][7:2]]);
            #1;
            vectors++; if (dbg_gnt !== 1'b1) begin miscompares++; $display("FAIL dbg_gnt[%0d]: got %b want 1", i, dbg_gnt); end
            vectors++; if (cpu_gnt !== 1'b0) begin miscompares++; $display("FAIL dbg_cpu_gnt[%0d]: got %b want 0", i, cpu_gnt); end
            vectors++; if (mem_we !== dw[i]) begin miscompares++; $display("FAIL dbg_mem_we[%0d]: got %b want %b", i, mem_we, dw[i]); end
            vectors++; if (mem_a !== da[i]) begin miscompares++; $display("FAIL dbg_mem_a[%0d]: got %h want %h", i, mem_a, da[i]); end
            @(posedge clk);
            if (dw[i]) shadow[da[i][7:2]] = dd[i];
            #1;
            vectors++; if (dbg_rvalid !== !dw[i]) begin miscompares++; $display("FAIL dbg_rvalid[%0d]: got %b want %b", i, dbg_rvalid, !dw[i]); end
            if (!dw[i]) begin
                if (sb_q.size() == 0) begin
                    vectors++; miscompares++; $display("FAIL dbg_sb_empty[%0d]: got empty want entry", i);
                end else begin
                    exp_v = sb_q.pop_front();
                    held  = exp_v;
                    vectors++; if (dbg_rdata !== exp_v) begin miscompares++; $display("FAIL dbg_rdata[%0d]: got %h want %h", i, dbg_rdata, exp_v); end
                end
            end
            @(negedge clk);
        end
        set_idle();
        @(posedge clk); #1;
        vectors++; if (dbg_rvalid !== 1'b0) begin miscompares++; $display("FAIL dbg_rvalid_pulse: got %b want 0", dbg_rvalid); end
        vectors++; if (dbg_rdata !== held) begin miscompares++; $display("FAIL dbg_rdata_hold: got %h want %h", dbg_rdata, held); end
        vectors++; if (held !== 32'h2222_2222) begin miscompares++; $display("FAIL dbg_read_value: got %h want 22222222", held); end
        @(negedge clk);
    endtask

    // Both ports saturated: CPU,DBG x4 repeating; stats after 10 cycles.
    task automatic test_contention();
        logic        exp_d;
        logic [31:0] exp_a;
        int          ndbg;
        pulse_reset();
        ndbg = 0;
        for (int i = 0; i < 10; i++) begin
            exp_d = (i % 5) != 0;
            exp_a = exp_d ? 32'h24 : 32'h20;
            set_cpu(1'b1, 1'b0, 32'h20, 32'h0);
            set_dbg(1'b1, 1'b1, 32'h24, 32'hA000_0000 + 32'(ndbg));
            #1;
            vectors++; if (cpu_gnt !== !exp_d) begin miscompares++; $display("FAIL cont_cpu_gnt[%0d]: got %b want %b", i, cpu_gnt, !exp_d); end
            vectors++; if (dbg_gnt !== exp_d) begin miscompares++; $display("FAIL cont_dbg_gnt[%0d]: got %b want %b", i, dbg_gnt, exp_d); end
            vectors++; if (cpu_stall !== exp_d) begin miscompares++; $display("FAIL cont_stall[%0d]: got %b want %b", i, cpu_stall, exp_d); end
            vectors++; if (mem_we !== exp_d) begin miscompares++; $display("FAIL cont_mem_we[%0d]: got %b want %b", i, mem_we, exp_d); end
            vectors++; if (mem_a !== exp_a) begin miscompares++; $display("FAIL cont_mem_a[%0d]: got %h want %h", i, mem_a, exp_a); end
            if (!exp_d) begin
                vectors++; if (cpu_rd !== shadow[8]) begin miscompares++; $display("FAIL cont_cpu_rd[%0d]: got %h want %h", i, cpu_rd, shadow[8]); end
            end
            @(posedge clk);
            if (exp_d) begin
                shadow[9] = 32'hA000_0000 + 32'(ndbg);
                ndbg++;
            end
            #1;
            @(negedge clk);
        end
        vectors++; if (stat_cpu_stall !== EXP_STAT) begin miscompares++; $display("FAIL stat_cpu_stall: got %0d want %0d", stat_cpu_stall, EXP_STAT); end
        vectors++; if (stat_dbg_xfer !== EXP_STAT) begin miscompares++; $display("FAIL stat_dbg_xfer: got %0d want %0d", stat_dbg_xfer, EXP_STAT); end
        set_idle();
        #1;
        vectors++; if (dmem[9] !== shadow[9]) begin miscompares++; $display("FAIL cont_dmem: got %h want %h", dmem[9], shadow[9]); end
        @(negedge clk);
    endtask

    // Reset in the middle of a debug tenure (burst_cnt=2) returns to CPU priority.
    task automatic test_reset_mid_tenure();
        logic exp_d;
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            exp_d = (i != 0);
            set_cpu(1'b1, 1'b0, 32'h20, 32'h0);
            set_dbg(1'b1, 1'b1, 32'h28, 32'h0BAD_0000);
            #1;
            vectors++; if (dbg_gnt !== exp_d) begin miscompares++; $display("FAIL mid_dbg_gnt[%0d]: got %b want %b", i, dbg_gnt, exp_d); end
            @(posedge clk);
            if (exp_d) shadow[10] = 32'h0BAD_0000;
            #1;
            @(negedge clk);
        end
        reset = 1'b1;
        set_cpu(1'b1, 1'b1, 32'h30, 32'hFFFF_0000);
        set_dbg(1'b1, 1'b1, 32'h34, 32'h0000_FFFF);
        #1;
        vectors++; if (cpu_gnt !== 1'b0) begin miscompares++; $display("FAIL mid_rst_cpu_gnt: got %b want 0", cpu_gnt); end
        vectors++; if (dbg_gnt !== 1'b0) begin miscompares++; $display("FAIL mid_rst_dbg_gnt: got %b want 0", dbg_gnt); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL mid_rst_mem_we: got %b want 0", mem_we); end
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b0;
        set_cpu(1'b1, 1'b0, 32'h30, 32'h0);
        set_dbg(1'b1, 1'b1, 32'h34, 32'h0000_FFFF);
        #1;
        vectors++; if (cpu_gnt !== 1'b1) begin miscompares++; $display("FAIL mid_post_cpu_gnt: got %b want 1", cpu_gnt); end
        vectors++; if (dbg_gnt !== 1'b0) begin miscompares++; $display("FAIL mid_post_dbg_gnt: got %b want 0", dbg_gnt); end
        vectors++; if (cpu_rd !== shadow[12]) begin miscompares++; $display("FAIL mid_post_cpu_rd: got %h want %h", cpu_rd, shadow[12]); end
        vectors++; if (dmem[12] !== shadow[12]) begin miscompares++; $display("FAIL mid_dmem_cpu: got %h want %h", dmem[12], shadow[12]); end
        vectors++; if (dmem[13] !== shadow[13]) begin miscompares++; $display("FAIL mid_dmem_dbg: got %h want %h", dmem[13], shadow[13]); end
        @(posedge clk); #1;
        @(negedge clk);
        set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        vectors++; if (cpu_gnt !== 1'b1) begin miscompares++; $display("FAIL mid_exit_cpu_gnt: got %b want 1", cpu_gnt); end
        @(posedge clk); #1;
        @(negedge clk);
        set_idle();
    endtask

    // Single debug read while the CPU is busy: served next cycle, then CPU priority again.
    task automatic test_single_dbg();
        logic        exp_c [6];
        logic        exp_d [6];
        logic        dreq  [6];
        logic [31:0] da    [6];
        exp_c = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_d = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        dreq  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        da    = '{32'h4, 32'h4, 32'h0, 32'h8, 32'h8, 32'h0};
        for (int i = 0; i < 6; i++) begin
            set_cpu(i < 5, 1'b0, 32'h20, 32'h0);
            set_dbg(dreq[i], 1'b0, da[i], 32'h0);
            if (exp_d[i]) sb_q.push_back(shadow[da[i][7:2]]);
            #1;
            vectors++; if (cpu_gnt !== exp_c[i]) begin miscompares++; $display("FAIL single_cpu_gnt[%0d]: got %b want %b", i, cpu_gnt, exp_c[i]); end
            vectors++; if (dbg_gnt !== exp_d[i]) begin miscompares++; $display("FAIL single_dbg_gnt[%0d]: got %b want %b", i, dbg_gnt, exp_d[i]); end
            @(posedge clk); #1;
            vectors++; if (dbg_rvalid !== exp_d[i]) begin miscompares++; $display("FAIL single_rvalid[%0d]: got %b want %b", i, dbg_rvalid, exp_d[i]); end
            if (exp_d[i]) begin
                if (sb_q.size() == 0) begin
                    vectors++; miscompares++; $display("FAIL single_sb_empty[%0d]: got empty want entry", i);
                end else begin
                    exp_v = sb_q.pop_front();
                    vectors++; if (dbg_rdata !== exp_v) begin miscompares++; $display("FAIL single_rdata[%0d]: got %h want %h", i, dbg_rdata, exp_v); end
                end
            end
            @(negedge clk);
        end
        set_idle();
        vectors++; if (sb_q.size() != 0) begin miscompares++; $display("FAIL sb_leftover: got %0d want 0", sb_q.size()); end
    endtask

    initial begin
        reset = 1'b1;
        set_idle();
        @(negedge clk);
        test_reset();
        test_cpu_only();
        test_debug_only();
        test_contention();
        test_reset_mid_tenure();
        test_single_dbg();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
